dmem_responder: RTL and testbench

//  Data-memory responder: the slave end of the CPU load/store interface. Accepts one word

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its RAM array.
package dmem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LAT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed RAM: one synchronous byte-enabled write port, one synchronous read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int n  = 32,
  parameter int AW = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [WORD_BYTES-1:0] be_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [n-1:0]          wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [n-1:0]          rdata_o
);

  logic [n-1:0] mem_q [2**AW];
  logic [n-1:0] rdata_q;

  // NOTE: storage has no reset branch, so contents survive reset and map onto plain RAM.
  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store slave: accepts one request, waits LATENCY cycles, then holds a response.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned accesses flagged, not performed).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int n       = 32,
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [n-1:0]          req_addr,
  input  logic [n-1:0]          req_wdata,
  input  logic [WORD_BYTES-1:0] req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [n-1:0]          rsp_rdata,
  output logic                  rsp_err
);

  state_e                state_q, state_d;
  logic [LAT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q;
  logic [AW-1:0]         idx_q;
  logic [1:0]            off_q;
  logic [n-1:0]          wdata_q;
  logic [WORD_BYTES-1:0] be_q;

  logic                  accept, commit, trap, arr_we, arr_re;
  logic                  op_we;
  logic [AW-1:0]         op_idx;
  logic [1:0]            op_off;
  logic [n-1:0]          op_wdata, arr_rdata;
  logic [WORD_BYTES-1:0] op_be;
  logic                  addr_unused;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        idx_q   <= req_addr[AW+1:2];
        off_q   <= req_addr[1:0];
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        if (LATENCY == 1) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LAT_W'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle builds commit on the accept edge, so they use the live request.
  always_comb begin
    if (LATENCY == 1) begin
      op_we    = req_we;
      op_idx   = req_addr[AW+1:2];
      op_off   = req_addr[1:0];
      op_wdata = req_wdata;
      op_be    = req_be;
    end else begin
      op_we    = we_q;
      op_idx   = idx_q;
      op_off   = off_q;
      op_wdata = wdata_q;
      op_be    = be_q;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap    = is_misaligned(op_off);
  assign rsp_err = rsp_valid && is_misaligned(off_q);
`else
  assign trap    = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // A reset on the commit edge must keep an uncommitted write out of the RAM.
  assign arr_we = commit && op_we && !trap && !reset;
  assign arr_re = commit && !op_we && !trap && !reset;

  assign rsp_rdata   = (rsp_valid && !we_q && !rsp_err) ? arr_rdata : '0;
  assign addr_unused = ^{req_addr[n-1:AW+2], op_off};

  dmem_array #(
    .n  (n),
    .AW (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .be_i    (op_be),
    .waddr_i (op_idx),
    .wdata_i (op_wdata),
    .re_i    (arr_re),
    .raddr_i (op_idx),
    .rdata_o (arr_rdata)
  );

  // A stalled request must be held unchanged until it is accepted.
  assert property (@(posedge clk) disable iff (reset)
    (req_valid && !req_ready) |=> (req_valid && $stable({req_we, req_addr, req_wdata, req_be})));

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench: two responders (LATENCY 2 and 1) share stimulus; a word-array model predicts responses.
module tb_dmem_responder;

  localparam int N  = 32;
  localparam int AW = 8;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        rv0, rv1, rr0, rr1;
  logic        rdy0, rdy1, vld0, vld1, err0, err1;
  logic [31:0] rdat0, rdat1;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic [31:0] mem [2][256];
  logic [31:0] last_rdata;
  int          checks   = 0;
  int          failures = 0;

  assign rv0 = req_valid && !sel;
  assign rv1 = req_valid && sel;
  assign rr0 = rsp_ready && !sel;
  assign rr1 = rsp_ready && sel;

  assign req_ready = sel ? rdy1 : rdy0;
  assign rsp_valid = sel ? vld1 : vld0;
  assign rsp_err   = sel ? err1 : err0;
  assign rsp_rdata = sel ? rdat1 : rdat0;

  dmem_responder #(.n(N), .AW(AW), .LATENCY(2)) u_dut_l2 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (rv0),
    .req_ready (rdy0),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (vld0),
    .rsp_ready (rr0),
    .rsp_rdata (rdat0),
    .rsp_err   (err0)
  );

  dmem_responder #(.n(N), .AW(AW), .LATENCY(1)) u_dut_l1 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (rv1),
    .req_ready (rdy1),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (vld1),
    .rsp_ready (rr1),
    .rsp_rdata (rdat1),
    .rsp_err   (err1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Issue one request, predict its response from the model, check latency and payload.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be);
    int          cyc;
    int          lat;
    logic [7:0]  idx;
    logic        mis;
    logic [31:0] exp_rdata;
    lat       = sel ? 1 : 2;
    idx       = addr[AW+1:2];
    mis       = TRAP && (addr[1:0] != 2'b00);
    exp_rdata = '0;
    if (we) begin
      if (!mis)
        for (int b = 0; b < 4; b++)
          if (be[b]) mem[sel][idx][8*b +: 8] = wdata[8*b +: 8];
    end else if (!mis) begin
      exp_rdata = mem[sel][idx];
    end
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    check("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc <= 20) begin
      check("req_ready_wait", req_ready, 0);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, lat);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", rsp_err, mis);
    check("req_ready_resp", req_ready, 0);
    last_rdata = exp_rdata;
  endtask

  // Hold off the response for 'hold' cycles, then take it.
  task automatic take(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, last_rdata);
      check("hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_released", rsp_valid, 0);
    check("ready_after_rsp", req_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] prev, addr;
    sel       = 1'b0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready_l2", rdy0, 1);
    check("rst_ready_l1", rdy1, 1);
    check("rst_valid_l2", vld0, 0);
    check("rst_valid_l1", vld1, 0);
    check("rst_rdata_l2", rdat0, 0);
    check("rst_err_l2", err0, 0);

    // Give both RAMs known contents.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 256; i++) begin
        addr = 32'(i) << 2;
        send(1'b1, addr, $urandom, 4'hF);
        take(0);
      end
    end

    // Reset during the wait state drops the write.
    sel       = 1'b0;
    prev      = mem[0][4];
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'hDEADBEEF;
    req_be    = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("in_wait_valid", rsp_valid, 0);
    check("in_wait_ready", req_ready, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("midwait_rst_valid", rsp_valid, 0);
    check("midwait_rst_ready", req_ready, 1);
    @(posedge clk); #1;
    check("midwait_rst_ready2", req_ready, 1);
    send(1'b0, 32'h10, '0, 4'h0);
    check("reset_kept_ram", rsp_rdata, prev);
    take(0);

    // Full write then read-back, then byte-enable merge.
    send(1'b1, 32'h20, 32'h12345678, 4'hF);
    take(0);
    send(1'b0, 32'h20, '0, 4'h0);
    check("full_write", rsp_rdata, 32'h12345678);
    take(0);
    send(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    take(0);
    send(1'b0, 32'h20, '0, 4'h0);
    check("be_merge", rsp_rdata, 32'h12BB56DD);

    // Backpressure with a second request waiting behind the response.
    req_we    = 1'b1;
    req_addr  = 32'h24;
    req_wdata = 32'h0BADF00D;
    req_be    = 4'hF;
    req_valid = 1'b1;
    take(5);
    send(1'b1, 32'h24, 32'h0BADF00D, 4'hF);
    take(0);
    send(1'b1, 32'h28, 32'hFFFFFFFF, 4'h0);
    take(1);
    send(1'b0, 32'h24, '0, 4'h0);
    check("queued_write", rsp_rdata, 32'h0BADF00D);
    take(0);

    // Address wrap on the single-cycle responder.
    sel = 1'b1;
    send(1'b1, 32'h400, 32'h0000CAFE, 4'hF);
    take(0);
    send(1'b0, 32'h000, '0, 4'h0);
    check("wrap_read", rsp_rdata, 32'h0000CAFE);
    take(0);

    // Misaligned write: trapped or aligned down depending on the build.
    sel  = 1'b0;
    prev = mem[0][8];
    send(1'b1, 32'h22, 32'h55667788, 4'hF);
    take(0);
    send(1'b0, 32'h20, '0, 4'h0);
    check("misalign_write", rsp_rdata, TRAP ? prev : 32'h55667788);
    take(0);

    // Randomized traffic across both responders.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      sel = 1'($urandom_range(0, 1));
      a   = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
      take(int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
